// File: rtl/phase_sequencer.sv
// Multi-cycle core control FSM: walks FETCH..WRITEBACK with per-stage stalls, qualifies
// the writeback commit strobes, counts retired instructions and traps stuck stages.
module phase_sequencer #(
    parameter int STALL_TIMEOUT = 16,
    parameter int INSTRET_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 clear_err,
    input  logic                 stall_fetch,
    input  logic                 stall_decode,
    input  logic                 stall_execute,
    input  logic                 stall_memory,
    input  logic                 stall_writeback,
    input  logic                 rd_write_mw,
    input  logic [4:0]           rdsel_mw,
    input  logic                 jump_state_wf,
    output logic                 phase_fetch,
    output logic                 phase_decode,
    output logic                 phase_execute,
    output logic                 phase_memory,
    output logic                 phase_writeback,
    output logic                 rf_we,
    output logic [4:0]           rf_wsel,
    output logic                 pc_load_jump,
    output logic [INSTRET_W-1:0] instret,
    output logic                 busy,
    output logic                 stall_err
);

    localparam int               CNT_W     = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, stall_cnt_inc;
    logic                 stall_err_q, stall_err_d;
    logic [INSTRET_W-1:0] instret_q;
    logic [4:0]           phase_q, phase_d;   // {W, M, E, D, F}
    logic                 stage_stall;
    logic                 commit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        stall_cnt_d   = '0;
        stall_err_d   = stall_err_q;
        commit        = 1'b0;
        stage_stall   = 1'b0;
        stall_cnt_inc = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);

        case (state_q)
            S_FETCH:     stage_stall = stall_fetch;
            S_DECODE:    stage_stall = stall_decode;
            S_EXECUTE:   stage_stall = stall_execute;
            S_MEMORY:    stage_stall = stall_memory;
            S_WRITEBACK: stage_stall = stall_writeback;
            default:     stage_stall = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK: begin
                if (stage_stall) begin
                    stall_cnt_d = stall_cnt_inc;
                    // A stuck stage aborts the instruction before it can commit.
                    if (stall_cnt_inc >= CNT_LIMIT) begin
                        state_d     = S_ERROR;
                        stall_err_d = 1'b1;
                    end
                end else begin
                    case (state_q)
                        S_FETCH:   state_d = S_DECODE;
                        S_DECODE:  state_d = S_EXECUTE;
                        S_EXECUTE: state_d = S_MEMORY;
                        S_MEMORY:  state_d = S_WRITEBACK;
                        default: begin
                            commit  = rst_n;
                            state_d = run ? S_FETCH : S_IDLE;
                        end
                    endcase
                end
            end
            S_ERROR: begin
                if (clear_err) begin
                    state_d     = S_IDLE;
                    stall_err_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        phase_d = '0;
        case (state_d)
            S_FETCH:     phase_d[0] = 1'b1;
            S_DECODE:    phase_d[1] = 1'b1;
            S_EXECUTE:   phase_d[2] = 1'b1;
            S_MEMORY:    phase_d[3] = 1'b1;
            S_WRITEBACK: phase_d[4] = 1'b1;
            default:     phase_d    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
            instret_q   <= '0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
            phase_q     <= phase_d;
            if (commit) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Commit strobes are live only in the non-stalled WRITEBACK cycle; x0 is never written.
    assign rf_we        = commit & rd_write_mw & (rdsel_mw != 5'd0);
    assign rf_wsel      = rf_we ? rdsel_mw : 5'd0;
    assign pc_load_jump = commit & jump_state_wf;

    assign phase_fetch     = phase_q[0];
    assign phase_decode    = phase_q[1];
    assign phase_execute   = phase_q[2];
    assign phase_memory    = phase_q[3];
    assign phase_writeback = phase_q[4];
    assign instret         = instret_q;
    assign stall_err       = stall_err_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_phase_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n, run, clear_err;
    logic        stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback;
    logic        rd_write_mw, jump_state_wf;
    logic [4:0]  rdsel_mw;
    logic        phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback;
    logic        rf_we, pc_load_jump, busy, stall_err;
    logic [4:0]  rf_wsel;
    logic [31:0] instret;

    // Narrow-counter instance fed the same stimulus, so counter wrap is reached quickly.
    logic        w3_pf, w3_pd, w3_pe, w3_pm, w3_pw, w3_we, w3_pc, w3_busy, w3_err;
    logic [4:0]  w3_wsel;
    logic [2:0]  w3_instret;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.STALL_TIMEOUT(TIMEOUT), .INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clear_err(clear_err),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
        .stall_memory(stall_memory), .stall_writeback(stall_writeback),
        .rd_write_mw(rd_write_mw), .rdsel_mw(rdsel_mw), .jump_state_wf(jump_state_wf),
        .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
        .phase_memory(phase_memory), .phase_writeback(phase_writeback),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .pc_load_jump(pc_load_jump),
        .instret(instret), .busy(busy), .stall_err(stall_err)
    );

    phase_sequencer #(.STALL_TIMEOUT(TIMEOUT), .INSTRET_W(3)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .run(run), .clear_err(clear_err),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
        .stall_memory(stall_memory), .stall_writeback(stall_writeback),
        .rd_write_mw(rd_write_mw), .rdsel_mw(rdsel_mw), .jump_state_wf(jump_state_wf),
        .phase_fetch(w3_pf), .phase_decode(w3_pd), .phase_execute(w3_pe),
        .phase_memory(w3_pm), .phase_writeback(w3_pw),
        .rf_we(w3_we), .rf_wsel(w3_wsel), .pc_load_jump(w3_pc),
        .instret(w3_instret), .busy(w3_busy), .stall_err(w3_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_phase 0=idle, 1..5 = fetch..writeback, 6 = error.
    int          m_phase = 0;
    int          m_stalls = 0;
    int unsigned m_instret = 0;
    bit          m_err = 1'b0;
    bit          model_valid = 1'b0;
    logic [4:0]  stall_vec;

    assign stall_vec = {stall_writeback, stall_memory, stall_execute, stall_decode, stall_fetch};

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0; m_stalls = 0; m_instret = 0; m_err = 1'b0;
                model_valid = 1'b1;
            end else if (m_phase == 0) begin
                if (run) m_phase = 1;
            end else if (m_phase == 6) begin
                if (clear_err) begin m_phase = 0; m_err = 1'b0; end
            end else if (stall_vec[m_phase-1]) begin
                m_stalls = m_stalls + 1;
                if (m_stalls >= TIMEOUT) begin m_phase = 6; m_err = 1'b1; m_stalls = 0; end
            end else begin
                m_stalls = 0;
                if (m_phase == 5) begin
                    m_instret = m_instret + 1;
                    m_phase   = run ? 1 : 0;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
    end

    initial begin
        bit commit_now;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                commit_now = rst_n && (m_phase == 5) && !stall_writeback;
                check("cmp_phase", {phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch},
                      (m_phase >= 1 && m_phase <= 5) ? 64'(1 << (m_phase - 1)) : 64'd0);
                check("cmp_busy", busy, (m_phase >= 1 && m_phase <= 5));
                check("cmp_stall_err", stall_err, m_err);
                check("cmp_rf_we", rf_we, commit_now && rd_write_mw && (rdsel_mw != 0));
                check("cmp_rf_wsel", rf_wsel, (commit_now && rd_write_mw && (rdsel_mw != 0)) ? rdsel_mw : 5'd0);
                check("cmp_pc_load", pc_load_jump, commit_now && jump_state_wf);
                check("cmp_instret", instret, m_instret);
                check("cmp_instret_w3", w3_instret, m_instret % 8);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Entered with the DUT in FETCH; leaves after the edge that follows the commit.
    task automatic do_instr(input int wb_stalls, input logic rdw, input logic [4:0] rd,
                            input logic jmp, input logic [31:0] exp_instret);
        rd_write_mw = rdw; rdsel_mw = rd; jump_state_wf = jmp;
        check("instr_entry_fetch", phase_fetch, 1'b1);
        repeat (3) step();
        for (int i = 0; i <= wb_stalls; i++) begin
            step();
            stall_writeback = (i < wb_stalls);
            stall_decode    = (i < wb_stalls);
            settle();
            check("wb_phase", phase_writeback, 1'b1);
            check("wb_rf_we", rf_we, (i == wb_stalls) && rdw && (rd != 5'd0));
            check("wb_rf_wsel", rf_wsel, ((i == wb_stalls) && rdw && (rd != 5'd0)) ? rd : 5'd0);
            check("wb_pc_load", pc_load_jump, (i == wb_stalls) && jmp);
        end
        step();
        settle();
        check("instr_instret", instret, exp_instret);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; clear_err = 1'b0;
        stall_fetch = 1'b0; stall_decode = 1'b0; stall_execute = 1'b0;
        stall_memory = 1'b0; stall_writeback = 1'b0;
        rd_write_mw = 1'b0; rdsel_mw = 5'd0; jump_state_wf = 1'b0;

        // 1: reset, then free-running walk
        repeat (2) step();
        settle();
        check("reset_phases", {phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch}, 5'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1; run = 1'b1; clear_err = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 3) clear_err = 1'b0;
            settle();
            check("walk_onehot", {phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch},
                  64'(1 << ((c - 1) % 5)));
        end
        check("walk_instret3", instret, 32'd3);

        // 2: stalled writeback with rd=7, then a write to x0
        do_instr(3, 1'b1, 5'd7, 1'b0, 32'd4);
        do_instr(0, 1'b1, 5'd0, 1'b0, 32'd5);

        // 3: jump strobe only on the commit cycle
        do_instr(2, 1'b0, 5'd3, 1'b1, 32'd6);

        // 4: run dropped during EXECUTE
        rd_write_mw = 1'b1; rdsel_mw = 5'd4; jump_state_wf = 1'b0;
        step();
        settle();
        check("stop_decode", phase_decode, 1'b1);
        step();
        run = 1'b0;
        step();
        step();
        settle();
        check("stop_commit_we", rf_we, 1'b1);
        check("stop_commit_wsel", rf_wsel, 5'd4);
        step();
        settle();
        check("stop_busy", busy, 1'b0);
        check("stop_instret", instret, 32'd7);
        repeat (3) step();
        settle();
        check("stop_no_fetch", phase_fetch, 1'b0);

        // 5: watchdog in MEMORY
        run = 1'b1;
        repeat (3) step();
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) stall_memory = 1'b1;
            settle();
            check("wd_memory_held", phase_memory, 1'b1);
        end
        step();
        settle();
        check("wd_err", stall_err, 1'b1);
        check("wd_phases", {phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch}, 5'd0);
        check("wd_busy", busy, 1'b0);
        check("wd_instret", instret, 32'd7);
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0; stall_memory = 1'b0; stall_fetch = 1'b1;
        settle();
        check("clr_err", stall_err, 1'b0);
        check("clr_idle_busy", busy, 1'b0);
        step();
        settle();
        check("clr_fetch", phase_fetch, 1'b1);
        step();
        stall_fetch = 1'b0;
        settle();
        check("fetch_stalled", phase_fetch, 1'b1);
        do_instr(0, 1'b1, 5'd9, 1'b0, 32'd8);
        check("w3_wrap", w3_instret, 3'd0);

        // 6: reset mid-DECODE
        step();
        settle();
        check("rst_mid_decode", phase_decode, 1'b1);
        rst_n = 1'b0;
        step();
        settle();
        check("rst_mid_phases", {phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch}, 5'd0);
        check("rst_mid_instret", instret, 32'd0);
        check("rst_mid_busy", busy, 1'b0);
        rst_n = 1'b1; run = 1'b0;
        step();
        settle();
        check("rst_after_idle", phase_fetch, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
